// File: rtl/lnvd_adc_hex_viewer_if.sv
// lnvd_adc_hex_viewer_if: switch/sample inputs and HEX segment outputs of the ADC hex viewer.
interface lnvd_adc_hex_viewer_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 12,
    parameter int DIGITS = 3
);
    logic [9:0]             SW_in;
    logic [N_CH*DATA_W-1:0] data_in;
    logic                   sample_valid_in;
    logic [DIGITS*8-1:0]    HEX_out;
    logic [7:0]             HEX_CH_out;
    modport master (output SW_in, data_in, sample_valid_in, input HEX_out, HEX_CH_out);
    modport slave  (input SW_in, data_in, sample_valid_in, output HEX_out, HEX_CH_out);
endinterface

// File: rtl/lnvd_adc_hex_viewer.sv
// lnvd_adc_hex_viewer: per-channel live/peak capture shown on 7-segment digits with auto-scan and freeze.
module lnvd_adc_hex_viewer #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 12,
    parameter int DIGITS     = 3,
    parameter int TICK_DIV   = 12_500_000,
    parameter int SCAN_TICKS = 8
) (
    input logic clk,
    input logic rst_n,
    lnvd_adc_hex_viewer_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(SCAN_TICKS + 1);
    localparam int NW = DIGITS * 4;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
    endfunction

    logic [9:0]        sw_s1, sw_s;
    logic              unused_sw;
    logic [DATA_W-1:0] live [N_CH];
    logic [DATA_W-1:0] pmax [N_CH];
    logic [DATA_W-1:0] pmin [N_CH];
    logic [TW-1:0]     tcnt;
    logic [DW-1:0]     dwell, nxt_dwell;
    logic [3:0]        ch, nxt_ch;
    logic [1:0]        disp_mode;
    logic [DATA_W-1:0] disp, src;
    logic [NW-1:0]     dpad;
    logic [DIGITS*8-1:0] hex;
    logic              scan, vld, tick, auto, last, ok;

    wire [3:0] sel_ch = sw_s[3:0];
    wire [1:0] mode   = sw_s[5:4];
    wire       clr    = sw_s[8];
    wire       frz    = sw_s[9];

    assign unused_sw = ^sw_s[7:6];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s  <= '0;
        end else begin
            sw_s1 <= bus.SW_in;
            sw_s  <= sw_s1;
        end

    // clear only governs the peak registers; the live register always loads
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            live <= '{default: '0};
            pmax <= '{default: '0};
            pmin <= '{default: '1};
        end else
            for (int k = 0; k < N_CH; k++) begin
                if (bus.sample_valid_in) live[k] <= bus.data_in[k*DATA_W +: DATA_W];
                if (clr) begin
                    pmax[k] <= '0;
                    pmin[k] <= '1;
                end else if (bus.sample_valid_in) begin
                    if (bus.data_in[k*DATA_W +: DATA_W] > pmax[k]) pmax[k] <= bus.data_in[k*DATA_W +: DATA_W];
                    if (bus.data_in[k*DATA_W +: DATA_W] < pmin[k]) pmin[k] <= bus.data_in[k*DATA_W +: DATA_W];
                end
            end

    assign tick      = tcnt == TW'(TICK_DIV - 1);
    assign auto      = mode == 2'b11;
    assign last      = dwell == DW'(SCAN_TICKS - 1);
    assign nxt_ch    = !auto ? sel_ch : !scan ? 4'd1 : !last ? ch : ch == 4'(N_CH) ? 4'd1 : ch + 4'd1;
    assign nxt_dwell = (!auto || !scan || last) ? '0 : dwell + 1'b1;

    always_comb begin
        src = '0;
        for (int k = 0; k < N_CH; k++)
            if (nxt_ch == 4'(k + 1)) src = mode == 2'b01 ? pmax[k] : mode == 2'b10 ? pmin[k] : live[k];
    end

    // a frozen tick still marks the display valid but moves nothing else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tcnt      <= '0;
            dwell     <= '0;
            ch        <= '0;
            scan      <= 1'b0;
            disp      <= '0;
            disp_mode <= '0;
            vld       <= 1'b0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (tick) begin
                vld <= 1'b1;
                if (!frz) begin
                    ch        <= nxt_ch;
                    dwell     <= nxt_dwell;
                    scan      <= auto;
                    disp      <= src;
                    disp_mode <= mode;
                end
            end
        end

    assign ok   = ch != 4'd0 && ch <= 4'(N_CH);
    assign dpad = NW'(disp);

    always_comb begin
        hex = '1;
        for (int i = 0; i < DIGITS; i++)
            hex[i*8 +: 8] = !vld ? 8'hFF : !ok ? 8'hBF :
                {!((disp_mode == 2'b01 && i == 0) || (disp_mode == 2'b10 && i == DIGITS - 1)), seg(dpad[i*4 +: 4])};
    end

    assign bus.HEX_out    = hex;
    assign bus.HEX_CH_out = !vld ? 8'hFF : {!frz, ok ? seg(ch) : 7'h3F};
endmodule

// File: tb/tb_lnvd_adc_hex_viewer.sv
// tb_lnvd_adc_hex_viewer: directed checks of live, peak, scan, freeze, dash and reset behaviour.
module tb_lnvd_adc_hex_viewer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tc;
    int         checks = 0;
    int         failures = 0;
    int         seq [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 1};

    lnvd_adc_hex_viewer_if #(.N_CH(4), .DATA_W(12), .DIGITS(3)) bus ();

    lnvd_adc_hex_viewer #(
        .N_CH(4), .DATA_W(12), .DIGITS(3), .TICK_DIV(4), .SCAN_TICKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // expected tick phase: the display updates on the edge where tc == 3
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tc <= 2'd0;
        else tc <= tc + 2'd1;

    function automatic logic [7:0] fnt(input int n);
        case (n)
            1: fnt = 8'hF9;
            2: fnt = 8'hA4;
            3: fnt = 8'hB0;
            4: fnt = 8'h99;
            default: fnt = 8'hFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic show(input string tag, input logic [23:0] hx, input logic [7:0] hc);
        chk({tag, "_hex"}, {8'h0, bus.HEX_out}, {8'h0, hx});
        chk({tag, "_ch"}, {24'h0, bus.HEX_CH_out}, {24'h0, hc});
    endtask

    task automatic wait_tc3();
        for (int i = 0; i < 8 && tc != 2'd3; i++) @(negedge clk);
    endtask

    task automatic next_tick(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tc3();
            @(negedge clk);
        end
    endtask

    task automatic sample(input logic [47:0] d);
        bus.data_in = d;
        bus.sample_valid_in = 1'b1;
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
    endtask

    // sync delay lines the clear pulse up with the sample edge for exactly one cycle
    task automatic clear_with_sample(input logic [9:0] sw, input logic [47:0] d);
        bus.SW_in = sw | 10'h100;
        @(negedge clk);
        bus.SW_in = sw;
        @(negedge clk);
        sample(d);
    endtask

    initial begin
        bus.SW_in = 10'h002;
        bus.data_in = '0;
        bus.sample_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        show("reset", 24'hFFFFFF, 8'hFF);
        rst_n = 1'b1;
        sample({12'h000, 12'h000, 12'hA5C, 12'h000});
        wait_tc3();
        show("pre_first_tick", 24'hFFFFFF, 8'hFF);
        next_tick(1);
        show("live_a5c", 24'h8892C6, 8'hA4);
        wait_tc3();
        sample({12'h000, 12'h000, 12'h3C7, 12'h000});
        show("tick_collide_old", 24'h8892C6, 8'hA4);
        next_tick(1);
        show("tick_collide_new", 24'hB0C6F8, 8'hA4);

        bus.SW_in = 10'h011;
        next_tick(2);
        sample({36'h0, 12'h100});
        sample({36'h0, 12'h7FF});
        sample({36'h0, 12'h050});
        next_tick(1);
        show("max_hold", 24'hF88E0E, 8'hF9);
        clear_with_sample(10'h011, {36'h0, 12'h020});
        sample({36'h0, 12'h030});
        next_tick(1);
        show("max_after_clear", 24'hC0B040, 8'hF9);

        bus.SW_in = 10'h021;
        next_tick(2);
        show("min_hold", 24'h40B0C0, 8'hF9);
        clear_with_sample(10'h021, {36'h0, 12'h123});
        next_tick(1);
        show("min_clear_collide", 24'h0E8E8E, 8'hF9);
        bus.SW_in = 10'h001;
        next_tick(2);
        show("live_took_sample", 24'hF9A4B0, 8'hF9);
        bus.SW_in = 10'h021;
        sample({36'h0, 12'h456});
        next_tick(2);
        show("min_new", 24'h199282, 8'hF9);

        sample({12'h444, 12'h333, 12'h222, 12'h111});
        next_tick(1);
        bus.SW_in = 10'h030;
        for (int i = 0; i < 9; i++) begin
            next_tick(1);
            show($sformatf("scan%0d", i), {3{fnt(seq[i])}}, fnt(seq[i]));
        end
        bus.SW_in = 10'h230;
        for (int i = 0; i < 10; i++) begin
            next_tick(1);
            show($sformatf("freeze%0d", i), {3{fnt(1)}}, fnt(1) & 8'h7F);
        end
        bus.SW_in = 10'h030;
        next_tick(1);
        show("unfreeze_dwell", {3{fnt(1)}}, fnt(1));
        next_tick(1);
        show("unfreeze_adv", {3{fnt(2)}}, fnt(2));

        bus.SW_in = 10'h000;
        next_tick(2);
        show("ch0_dash", 24'hBFBFBF, 8'hBF);
        bus.SW_in = 10'h007;
        next_tick(2);
        show("ch7_dash", 24'hBFBFBF, 8'hBF);

        bus.SW_in = 10'h030;
        next_tick(3);
        bus.SW_in = 10'h021;
        rst_n = 1'b0;
        #1;
        show("reset_mid", 24'hFFFFFF, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tc3();
        show("reset_blank", 24'hFFFFFF, 8'hFF);
        next_tick(1);
        show("reset_min", 24'h0E8E8E, 8'hF9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
